// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. It sequences fetch, decode, execute, memory
// and writeback over one shared ALU and one unified memory port. It also
// handles the memory-ready handshake with a wait timeout, optional bne
// decoding, and illegal-opcode and instruction-done reporting.
module mips_multicycle_ctrl #(
  parameter int OPCODE_W    = 6,
  parameter int EN_BNE      = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                pcwrite,
  output logic                branch,
  output logic                branch_ne,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluop,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ERROR
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_TIMEOUT - 1);
  localparam bit               BNE_EN     = (EN_BNE != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             timeout_hit;

  // Saturating wait-counter increment and the timeout condition.
  // A timeout fires only while mem_ready is low, so a completing access wins.
  always_comb begin
    wait_cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    timeout_hit  = TIMEOUT_EN && (wait_cnt_q == CNT_LAST);
  end

  // State and wait-counter registers; reset returns the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: Non-blocking assignments let every flop sample the values from
      // before this edge, so the order of the statements does not matter.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic and Moore outputs, decoded from the current state.
  always_comb begin
    // NOTE: Every signal gets a default before the case statement, so no
    // path can leave a value unassigned and create a latch.
    state_d    = state_q;
    wait_cnt_d = '0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERROR;
        else                  wait_cnt_d = wait_cnt_inc;
      end

      S_DECODE: begin
        alusrcb = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_BNE && BNE_EN)    state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_ERROR;
        else                  wait_cnt_d = wait_cnt_inc;
      end

      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_ERROR;
        else                  wait_cnt_d = wait_cnt_inc;
      end

      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = (opcode == OP_BEQ);
        branch_ne  = BNE_EN && (opcode == OP_BNE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ERROR: bus_error = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore-style control FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Shares one ALU and one unified memory port between instruction and data accesses.
- Adds a memory-ready handshake with a wait-timeout, optional bne support, and illegal-opcode and instruction-done reporting.
- Sits between the instruction register opcode field and the multicycle datapath muxes and enables.

Parameters:
OPCODE_W, 6, opcode field width
EN_BNE, 1, 1 = decode bne (000101); 0 = bne is illegal
MEM_TIMEOUT, 16, max wait cycles per memory access before bus error; 0 disables the timeout
CNT_W, 5, wait-counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  instruction register bits [31:26]
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
iord  out  1  0 = address from PC; 1 = address from ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC load
branch  out  1  PC load if ALU zero
branch_ne  out  1  PC load if ALU not zero
regwrite  out  1  register file write
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = writeback from data register
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
aluop  out  2  00 = add, 01 = sub, 10 = funct
instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
illegal_op  out  1  one-cycle pulse in DECODE on an undecoded opcode
bus_error  out  1  sticky; high in ERROR

Behaviour:
- Reset: state = IDLE, wait counter = 0. All outputs are 0 while rst_n is low and in IDLE. IDLE always goes to FETCH on the next cycle.
- Outputs are combinational from state. Any output not listed for a state is 0. Only irwrite, pcwrite and MEMWR's instr_done are additionally qualified by mem_ready.
- FETCH:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite = pcwrite = mem_ready.
  - Transition: go to DECODE when mem_ready=1, else stay.
- DECODE:
  - Outputs: alusrcb=11, aluop=00.
  - 100011 and 101011 go to MEMADR; 000000 to EXECUTE; 001000 to ADDIEX; 000100 to BRANCH; 000101 to BRANCH if EN_BNE, else illegal; 000010 to JUMP.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH. Nothing else is written.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw. Opcode is held stable by the IR.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1; instr_done = mem_ready. Goes to FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 for beq, branch_ne=1 for bne (never both); instr_done=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Goes to FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Cleared on entry to each of these states.
  - Increments each cycle mem_ready=0, saturating.
  - If MEM_TIMEOUT>0, counter == MEM_TIMEOUT-1 and mem_ready=0: next state ERROR.
  - mem_ready=1 in that same cycle wins; the access completes normally.
- ERROR: all outputs 0 except bus_error=1. Exit only by reset.
- Async reset mid-instruction: outputs drop to 0 immediately, and any in-flight memwrite is deasserted.
- Cycle counts with mem_ready tied 1:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
  - Each wait cycle adds 1.

Test Plan:
- Reset release, mem_ready=1, opcode=100011 -> IDLE then FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5 after FETCH entry; instr_done pulses once.
- opcode=101011, mem_ready low 2 cycles in MEMWR -> memwrite high 3 cycles, instr_done only in the mem_ready cycle, then FETCH.
- opcode=000101 with EN_BNE=1 -> BRANCH with branch_ne=1, branch=0, aluop=01, pcsrc=01; with EN_BNE=0 -> illegal_op pulse in DECODE, then FETCH, no regwrite or memwrite.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR after 4 FETCH cycles, bus_error=1 sticky, irwrite never asserted. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
- opcode=000010 -> JUMP: pcwrite=1, pcsrc=10; next state FETCH. opcode=000000 -> EXECUTE aluop=10, then ALUWB regdst=1, regwrite=1.
- Assert rst_n low during MEMWR with memwrite=1 -> memwrite and all outputs 0 asynchronously; after release IDLE, FETCH, counter 0.
